// File: rtl/muldiv_unit_pkg.sv
// Shared multiply/divide op encodings and FSM state type.
// The control unit uses the same MD_* constants when issuing MULT/MULTU/DIV/DIVU.
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFin
  } md_state_e;

  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned datapath: radix-2 shift-add multiply and restoring divide.
// One shared WIDTH+1 bit adder/subtractor; one step per enabled cycle.
module muldiv_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [2*WIDTH-1:0] acc_next
);

  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic               is_div_q;
  logic [WIDTH:0]     add_x, add_y, sum;

  // Multiply adds the multiplicand to the upper half; divide subtracts the
  // divisor from the shifted remainder, with sum[WIDTH] acting as the borrow.
  always_comb begin
    add_x = is_div_q ? acc_q[2*WIDTH-1:WIDTH-1] : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    add_y = is_div_q ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    sum   = add_x + add_y + (WIDTH+1)'(is_div_q);
    if (is_div_q) begin
      if (sum[WIDTH]) begin
        acc_next = {acc_q[2*WIDTH-2:0], 1'b0};
      end else begin
        acc_next = {sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      if (acc_q[0]) begin
        acc_next = {sum, acc_q[WIDTH-1:1]};
      end else begin
        acc_next = {1'b0, acc_q[2*WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
    end else if (load) begin
      acc_q    <= {{WIDTH{1'b0}}, op_a};
      opnd_q   <= op_b;
      is_div_q <= is_div;
    end else if (step) begin
      acc_q    <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multiply/divide unit with architectural HI/LO: FSM, iteration counter,
// sign handling around the unsigned iterative core, and MTHI/MTLO writes.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH);

  md_state_e          state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, neg_res_q, neg_rem_q, div_zero_q;
  logic               load, step, sgn, op_div;
  logic [WIDTH-1:0]   mag_a, mag_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] acc_next, prod_fix;

  assign sgn    = md_is_signed(op);
  assign op_div = md_is_div(op);
  assign mag_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign mag_b  = (sgn && b[WIDTH-1]) ? -b : b;

  muldiv_iter #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .is_div   (op_div),
    .op_a     (mag_a),
    .op_b     (mag_b),
    .acc_next (acc_next)
  );

  // Divide by zero leaves an all-ones quotient; it must not be negated.
  assign prod_fix = neg_res_q ? -acc_next : acc_next;
  assign quo_fix  = (neg_res_q && !div_zero_q) ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          cnt_d   = '0;
          load    = 1'b1;
        end else begin
          if (hi_we) hi_d = wdata;
          if (lo_we) lo_d = wdata;
        end
      end
      StRun: begin
        step  = 1'b1;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StFin;
          cnt_d   = '0;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[2*WIDTH-1:WIDTH];
            lo_d = prod_fix[WIDTH-1:0];
          end
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      if (load) begin
        is_div_q   <= op_div;
        neg_res_q  <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
        neg_rem_q  <= sgn && a[WIDTH-1];
        div_zero_q <= (b == '0);
      end
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StFin);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed corner cases plus randomized
// ops and MTHI/MTLO writes checked against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_hi, exp_lo;

  always #5 clk = ~clk;

  muldiv_unit #(
    .WIDTH (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference result {hi, lo} from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x,
                                             input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy, uq, ur;
    logic [63:0]     res;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'h0, x};
    uy = {32'h0, y};
    res = '0;
    case (o)
      2'b00: res = sx * sy;
      2'b01: res = ux * uy;
      default: begin
        if (y == 32'h0) begin
          res = {x, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
          q = sx / sy;
          r = sx % sy;
          res = {r[31:0], q[31:0]};
        end else begin
          uq = ux / uy;
          ur = ux % uy;
          res = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return res;
  endfunction

  // Launch one op; optionally inject a stray start / hi_we at a given edge index.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input bit with_lo_we, input int inj_start, input int inj_we);
    logic [63:0] r;
    int          busy_cnt, done_edge, done_cnt;
    string       tag;
    r         = ref_result(o, x, y);
    busy_cnt  = 0;
    done_edge = -1;
    done_cnt  = 0;
    tag       = $sformatf("op%0d_%h_%h", o, x, y);
    start     = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    lo_we     = with_lo_we;
    wdata     = $urandom;
    tick();
    start = 1'b0;
    lo_we = 1'b0;
    op    = 2'($urandom);
    a     = $urandom;
    b     = $urandom;
    if (busy) busy_cnt++;
    for (int k = 1; k <= 36; k++) begin
      start = (k == inj_start);
      hi_we = (k == inj_we);
      wdata = $urandom;
      tick();
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_edge < 0) done_edge = k;
      end
    end
    start  = 1'b0;
    hi_we  = 1'b0;
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    check_eq({tag, " busy_cycles"}, 64'(busy_cnt), 64'd32);
    check_eq({tag, " done_edge"}, 64'(done_edge), 64'd32);
    check_eq({tag, " done_width"}, 64'(done_cnt), 64'd1);
    check_eq({tag, " hi"}, {32'h0, hi}, {32'h0, exp_hi});
    check_eq({tag, " lo"}, {32'h0, lo}, {32'h0, exp_lo});
  endtask

  task automatic mt(input bit wh, input bit wl, input logic [31:0] d);
    hi_we = wh;
    lo_we = wl;
    wdata = d;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b0;
    if (wh) exp_hi = d;
    if (wl) exp_lo = d;
    check_eq("mt hi", {32'h0, hi}, {32'h0, exp_hi});
    check_eq("mt lo", {32'h0, lo}, {32'h0, exp_lo});
  endtask

  initial begin
    int          dn;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1;
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    wdata = '0;
    tick();
    tick();
    check_eq("reset busy", {63'h0, busy}, 64'h0);
    check_eq("reset done", {63'h0, done}, 64'h0);
    check_eq("reset hi", {32'h0, hi}, 64'h0);
    check_eq("reset lo", {32'h0, lo}, 64'h0);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, 0);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, 0, 0);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 0, 0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 0);
    run_op(2'b10, 32'h0000_1234, 32'd0, 1'b0, 0, 0);
    run_op(2'b11, 32'hDEAD_BEEF, 32'd0, 1'b0, 0, 0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 0);
    run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 0, 0);
    run_op(2'b00, 32'd5, 32'd6, 1'b0, 3, 4);

    mt(1'b1, 1'b0, 32'hA5A5_A5A5);
    run_op(2'b01, 32'd2, 32'd3, 1'b1, 0, 0);
    mt(1'b1, 1'b1, 32'h1357_9BDF);

    // Reset in the middle of a divide aborts it.
    start = 1'b1;
    op    = 2'b10;
    a     = 32'h0123_4567;
    b     = 32'h0000_0089;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 9; k++) tick();
    reset = 1'b1;
    tick();
    check_eq("abort busy", {63'h0, busy}, 64'h0);
    check_eq("abort hi", {32'h0, hi}, 64'h0);
    check_eq("abort lo", {32'h0, lo}, 64'h0);
    reset  = 1'b0;
    exp_hi = '0;
    exp_lo = '0;
    dn     = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done || busy) dn++;
    end
    check_eq("abort no_done", 64'(dn), 64'h0);

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(3) == 0) mt(1'($urandom), 1'($urandom), $urandom);
      ro = 2'($urandom);
      ra = $urandom;
      case ($urandom_range(5))
        0:       rb = 32'h0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = $urandom_range(15);
        default: rb = $urandom;
      endcase
      if ($urandom_range(7) == 0) ra = 32'h8000_0000;
      run_op(ro, ra, rb, 1'($urandom), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
